// File: rtl/dfu_tile_sched.sv
// Tile-level read scheduler: per GEMM tile, issues diagonally skewed A/B SRAM reads
// and one mux streaming window, then waits for the systolic array to drain.
module dfu_tile_sched #(
   parameter int no_of_sram_banks = 4,
   parameter int ROW              = 4,
   parameter int El_RC            = 4,
   parameter int ADDR_W           = 10,
   parameter int TILE_W           = 8,
   parameter int DRAIN_CYC        = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cfg_start,
   input  logic [TILE_W-1:0]                  cfg_num_tiles,
   input  logic [ADDR_W-1:0]                  cfg_base_a,
   input  logic [ADDR_W-1:0]                  cfg_base_b,
   input  logic [ADDR_W-1:0]                  cfg_tile_stride,
   input  logic                               sys2dfu_ready,
   output logic                               dfu2mux_rd_en,
   output logic [no_of_sram_banks-1:0]        sram_a_rd_en,
   output logic [no_of_sram_banks-1:0]        sram_b_rd_en,
   output logic [ADDR_W*no_of_sram_banks-1:0] sram_a_addr,
   output logic [ADDR_W*no_of_sram_banks-1:0] sram_b_addr,
   output logic                               sched_busy,
   output logic                               sched_done,
   output logic [TILE_W-1:0]                  tile_idx
);

   localparam int STREAM_LEN = El_RC + ROW - 1;
   localparam int CNT_W      = $clog2(STREAM_LEN + 1);
   localparam int DRN_W      = $clog2(DRAIN_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STREAM_LEN - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DRN_W-1:0]  r_drain;
   logic [TILE_W-1:0] r_tile_idx;
   logic [TILE_W-1:0] r_num_tiles;
   logic [ADDR_W-1:0] r_tile_base_a;
   logic [ADDR_W-1:0] r_tile_base_b;
   logic [ADDR_W-1:0] r_stride;
   logic [TILE_W-1:0] w_tile_next;

   assign w_tile_next = r_tile_idx + TILE_W'(1);
   assign tile_idx    = r_tile_idx;

   // Tile bases advance by the stride on each new tile instead of multiplying tile_idx*stride.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_drain       <= '0;
         r_tile_idx    <= '0;
         r_num_tiles   <= '0;
         r_tile_base_a <= '0;
         r_tile_base_b <= '0;
         r_stride      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  r_num_tiles   <= cfg_num_tiles;
                  r_tile_base_a <= cfg_base_a;
                  r_tile_base_b <= cfg_base_b;
                  r_stride      <= cfg_tile_stride;
                  r_tile_idx    <= '0;
                  r_cnt         <= '0;
                  r_drain       <= '0;
                  r_state       <= (cfg_num_tiles == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (sys2dfu_ready) begin
                  r_cnt   <= '0;
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (r_cnt == CNT_LAST) begin
                  r_drain <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (r_drain == DRN_LAST) begin
                  if (w_tile_next == r_num_tiles) begin
                     r_state <= S_DONE;
                  end else begin
                     r_tile_idx    <= w_tile_next;
                     r_tile_base_a <= r_tile_base_a + r_stride;
                     r_tile_base_b <= r_tile_base_b + r_stride;
                     r_state       <= S_LOAD;
                  end
               end else begin
                  r_drain <= r_drain + DRN_W'(1);
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode only registered state, so reset clears them without waiting for a clock.
   always_comb begin
      sched_busy    = (r_state != S_IDLE);
      sched_done    = (r_state == S_DONE);
      dfu2mux_rd_en = (r_state == S_STREAM);
      sram_a_rd_en  = '0;
      sram_b_rd_en  = '0;
      sram_a_addr   = '0;
      sram_b_addr   = '0;
      for (int i = 0; i < ROW; i++) begin
         if ((r_state == S_STREAM) && (int'(r_cnt) >= i) && (int'(r_cnt) < El_RC + i)) begin
            sram_a_rd_en[i]                 = 1'b1;
            sram_b_rd_en[i]                 = 1'b1;
            sram_a_addr[i*ADDR_W +: ADDR_W] = r_tile_base_a + ADDR_W'(int'(r_cnt) - i);
            sram_b_addr[i*ADDR_W +: ADDR_W] = r_tile_base_b + ADDR_W'(int'(r_cnt) - i);
         end
      end
   end

endmodule
